mem_llsc_ctrl: RTL

MEM-stage load/store controller for word accesses: LW, SW, LL and SC.
- Runs the data-bus request/acknowledge handshake and stalls the pipeline while a transfer is outstanding.
- Resolves SC success using the LLbit value, with a write-back-stage forward.
- Produces the write-enable/value pair that drives the LLbit register downstream.
- Sits between the EX/MEM pipeline register and the MEM/WB register.

---
 rtl/mem_llsc_ctrl_pkg.sv | 21 ++
 rtl/mem_llsc_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mem_llsc_ctrl_pkg.sv
// rtl/mem_llsc_ctrl_pkg.sv - shared MEM-stage op encodings and address-error exception codes
package mem_llsc_ctrl_pkg;

  localparam logic [2:0] MEM_OP_NONE = 3'd0;
  localparam logic [2:0] MEM_OP_LW   = 3'd1;
  localparam logic [2:0] MEM_OP_SW   = 3'd2;
  localparam logic [2:0] MEM_OP_LL   = 3'd3;
  localparam logic [2:0] MEM_OP_SC   = 3'd4;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  function automatic logic mem_op_known(input logic [2:0] op);
    return (op == MEM_OP_LW) || (op == MEM_OP_SW) || (op == MEM_OP_LL) || (op == MEM_OP_SC);
  endfunction

  function automatic logic mem_op_writes(input logic [2:0] op);
    return (op == MEM_OP_SW) || (op == MEM_OP_SC);
  endfunction

endpackage

// File: rtl/mem_llsc_ctrl.sv
// rtl/mem_llsc_ctrl.sv - MEM-stage LW/SW/LL/SC controller with bus handshake and SC resolution
module mem_llsc_ctrl
  import mem_llsc_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid_i,
  input  logic [2:0]        mem_op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              llbit_i,
  input  logic              wb_llbit_we_i,
  input  logic              wb_llbit_value_i,
  input  logic              flush,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [3:0]        bus_sel_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              stall_req_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              exc_adel_o,
  output logic              exc_ades_o,
  output logic              llbit_we_o,
  output logic              llbit_value_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic eff_llbit, issue, misaligned, sc_fail, start, in_bus;

  always_comb begin
    eff_llbit  = wb_llbit_we_i ? wb_llbit_value_i : llbit_i;
    issue      = (state_q == ST_IDLE) && op_valid_i && mem_op_known(mem_op_i) && !flush;
    misaligned = addr_i[1:0] != 2'b00;
    sc_fail    = issue && !misaligned && (mem_op_i == MEM_OP_SC) && !eff_llbit;
    start      = issue && !misaligned && !sc_fail;
    in_bus     = (state_q == ST_WAIT) || (state_q == ST_DRAIN);

    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    sel_d    = sel_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT;
          op_d    = mem_op_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          we_d    = mem_op_writes(mem_op_i);
          sel_d   = 4'b1111;
        end
      end
      ST_WAIT: begin
        // A flush cannot abort the bus transfer; it only discards its outcome.
        if (bus_ack_i && flush) begin
          state_d = ST_IDLE;
        end else if (bus_ack_i) begin
          state_d = ST_DONE;
          if (op_q == MEM_OP_LW || op_q == MEM_OP_LL) begin
            result_d = bus_rdata_i;
          end else if (op_q == MEM_OP_SC) begin
            result_d = DATA_W'(1);
          end else begin
            result_d = '0;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_DRAIN: if (bus_ack_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= MEM_OP_NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      sel_q    <= 4'b0000;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    bus_req_o     = in_bus;
    bus_we_o      = we_q;
    bus_addr_o    = addr_q;
    bus_wdata_o   = wdata_q;
    bus_sel_o     = sel_q;
    stall_req_o   = start || in_bus;
    done_o        = sc_fail || ((state_q == ST_DONE) && !flush);
    result_o      = sc_fail ? '0 : result_q;
    exc_adel_o    = issue && misaligned && !mem_op_writes(mem_op_i);
    exc_ades_o    = issue && misaligned && mem_op_writes(mem_op_i);
    // Only successful SCs reach DONE, so SC there always clears the LLbit.
    llbit_we_o    = (state_q == ST_DONE) && !flush && (op_q == MEM_OP_LL || op_q == MEM_OP_SC);
    llbit_value_o = llbit_we_o && (op_q == MEM_OP_LL);
  end

endmodule
